sbyte_share_arbiter: RTL and testbench

- Time-multiplexes one 32-bit S-box bank (4 sub_byte instances, one per byte lane) between two requesters.
- Requester 1 is the AES state path: a 128-bit SubBytes job, processed one word per beat.
- Requester 2 is the key-expansion path: a 32-bit SubWord job, one beat.
- Replaces four parallel 128-bit S-box copies with one 32-bit bank, for area-constrained builds of the AES round datapath.

---
 rtl/sbyte_share_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sbyte_share_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sbyte_share_arbiter.sv
// One 32-bit S-box bank time-shared between a 128-bit SubBytes job (state path)
// and single-word SubWord requests (key-expansion path).

module sub_byte (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      else      p = p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the cipher requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  assign out_byte = sbox_f(in_byte);

endmodule

module sbyte_share_arbiter #(
  parameter logic KEY_PRIO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_req_valid,
  output logic         st_req_ready,
  input  logic [127:0] st_req_data,
  output logic         st_rsp_valid,
  output logic [127:0] st_rsp_data,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_req_word,
  output logic         key_rsp_valid,
  output logic [31:0]  key_rsp_word
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [1:0]     cnt_r;
  logic [1:0]     cnt_next_s;
  logic           last_key_r;
  logic           last_key_next_s;
  logic [127:0]   buf_r;
  logic [127:0]   buf_next_s;
  logic           busy_s;
  logic           st_go_s;
  logic           key_go_s;
  logic           st_beat_s;
  logic           st_done_s;
  logic [31:0]    cur_word_s;
  logic [31:0]    bank_in_s;
  logic [31:0]    bank_out_s;
  logic           st_rsp_valid_r;
  logic [127:0]   st_rsp_data_r;
  logic           key_rsp_valid_r;
  logic [31:0]    key_rsp_word_r;

  assign busy_s        = (state_r == ST_BUSY);
  assign st_req_ready  = ~busy_s;
  // last_key forces a state beat after every key beat, so neither side starves.
  assign key_req_ready = ~busy_s | (KEY_PRIO & ~last_key_r);
  assign st_go_s       = st_req_valid & ~busy_s;
  assign key_go_s      = key_req_valid & key_req_ready;
  assign st_beat_s     = busy_s & ~key_go_s;

  // Pick the buffered state word addressed by the beat counter.
  always_comb begin
    cur_word_s = buf_r[127:96];
    case (cnt_r)
      2'd0:    cur_word_s = buf_r[127:96];
      2'd1:    cur_word_s = buf_r[95:64];
      2'd2:    cur_word_s = buf_r[63:32];
      2'd3:    cur_word_s = buf_r[31:0];
      default: cur_word_s = buf_r[127:96];
    endcase
  end

  assign bank_in_s = key_go_s ? key_req_word : cur_word_s;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    sub_byte u_sub_byte (
      .in_byte  (bank_in_s[8*g +: 8]),
      .out_byte (bank_out_s[8*g +: 8])
    );
  end

  // Next-state logic: job accept, beat selection and in-place write-back.
  always_comb begin
    state_next_s    = state_r;
    cnt_next_s      = cnt_r;
    last_key_next_s = last_key_r;
    buf_next_s      = buf_r;
    st_done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        last_key_next_s = 1'b0;
        if (st_go_s) begin
          state_next_s = ST_BUSY;
          cnt_next_s   = 2'd0;
          buf_next_s   = st_req_data;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (st_beat_s) begin
          last_key_next_s = 1'b0;
          cnt_next_s      = cnt_r + 2'd1;
          case (cnt_r)
            2'd0:    buf_next_s[127:96] = bank_out_s;
            2'd1:    buf_next_s[95:64]  = bank_out_s;
            2'd2:    buf_next_s[63:32]  = bank_out_s;
            2'd3:    buf_next_s[31:0]   = bank_out_s;
            default: buf_next_s         = buf_r;
          endcase
          if (cnt_r == 2'd3) begin
            state_next_s = ST_IDLE;
            st_done_s    = 1'b1;
          end else begin
            state_next_s = ST_BUSY;
          end
        end else begin
          last_key_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        cnt_next_s      = 2'd0;
        last_key_next_s = 1'b0;
      end
    endcase
  end

  // FSM and job buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      last_key_r <= 1'b0;
      buf_r      <= 128'd0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      last_key_r <= last_key_next_s;
      buf_r      <= buf_next_s;
    end
  end

  // Response registers; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_rsp_valid_r  <= 1'b0;
      st_rsp_data_r   <= 128'd0;
      key_rsp_valid_r <= 1'b0;
      key_rsp_word_r  <= 32'd0;
    end else begin
      st_rsp_valid_r  <= st_done_s;
      key_rsp_valid_r <= key_go_s;
      if (st_done_s) st_rsp_data_r <= buf_next_s;
      else           st_rsp_data_r <= st_rsp_data_r;
      if (key_go_s)  key_rsp_word_r <= bank_out_s;
      else           key_rsp_word_r <= key_rsp_word_r;
    end
  end

  assign st_rsp_valid  = st_rsp_valid_r;
  assign st_rsp_data   = st_rsp_data_r;
  assign key_rsp_valid = key_rsp_valid_r;
  assign key_rsp_word  = key_rsp_word_r;

endmodule

// File: tb/tb_sbyte_share_arbiter.sv
// Directed bench: two arbiters (KEY_PRIO=1 and KEY_PRIO=0) share one stimulus stream.
module tb_sbyte_share_arbiter;

  logic         clk;
  logic         rst;
  logic         st_req_valid;
  logic [127:0] st_req_data;
  logic         key_req_valid;
  logic [31:0]  key_req_word;

  logic         p1_st_req_ready, p1_st_rsp_valid, p1_key_req_ready, p1_key_rsp_valid;
  logic [127:0] p1_st_rsp_data;
  logic [31:0]  p1_key_rsp_word;
  logic         p0_st_req_ready, p0_st_rsp_valid, p0_key_req_ready, p0_key_rsp_valid;
  logic [127:0] p0_st_rsp_data;
  logic [31:0]  p0_key_rsp_word;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] D_A   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] E_A   = 128'h638293C3_1BFC33F5_C4EEACEA_4BC12816;
  localparam logic [127:0] D_B   = 128'h53535353_00010203_00000000_FFFFFFFF;
  localparam logic [127:0] E_B   = 128'hEDEDEDED_637C777B_63636363_16161616;
  localparam logic [127:0] D_C   = 128'h0F0F0F0F_F0F0F0F0_01010101_10101010;
  localparam logic [127:0] E_C   = 128'h76767676_8C8C8C8C_7C7C7C7C_CACACACA;
  localparam logic [127:0] D_D   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] E_D   = 128'h7C266E85_A762BDDF_BB86F446_382023CA;

  sbyte_share_arbiter #(.KEY_PRIO(1'b1)) u_p1 (
    .clk(clk), .rst(rst),
    .st_req_valid(st_req_valid), .st_req_ready(p1_st_req_ready), .st_req_data(st_req_data),
    .st_rsp_valid(p1_st_rsp_valid), .st_rsp_data(p1_st_rsp_data),
    .key_req_valid(key_req_valid), .key_req_ready(p1_key_req_ready), .key_req_word(key_req_word),
    .key_rsp_valid(p1_key_rsp_valid), .key_rsp_word(p1_key_rsp_word)
  );

  sbyte_share_arbiter #(.KEY_PRIO(1'b0)) u_p0 (
    .clk(clk), .rst(rst),
    .st_req_valid(st_req_valid), .st_req_ready(p0_st_req_ready), .st_req_data(st_req_data),
    .st_rsp_valid(p0_st_rsp_valid), .st_rsp_data(p0_st_rsp_data),
    .key_req_valid(key_req_valid), .key_req_ready(p0_key_req_ready), .key_req_word(key_req_word),
    .key_rsp_valid(p0_key_rsp_valid), .key_rsp_word(p0_key_rsp_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    st_req_valid = 1'b0;
    st_req_data = 128'd0;
    key_req_valid = 1'b0;
    key_req_word = 32'd0;
    cyc();
    cyc();
    chk_b("rst_st_rsp_valid", p1_st_rsp_valid, 1'b0);
    chk_b("rst_key_rsp_valid", p1_key_rsp_valid, 1'b0);
    chk("rst_st_rsp_data", p1_st_rsp_data, 128'd0);
    chk("rst_key_rsp_word", 128'(p1_key_rsp_word), 128'd0);
    rst = 1'b0;
    cyc();
    chk_b("rst_st_ready", p1_st_req_ready, 1'b1);
    chk_b("rst_key_ready", p1_key_req_ready, 1'b1);
    chk_b("rst_p0_key_ready", p0_key_req_ready, 1'b1);

    // key alone
    key_req_valid = 1'b1;
    key_req_word = 32'h00010203;
    cyc();
    key_req_valid = 1'b0;
    key_req_word = 32'hFFFFFFFF;
    chk_b("key_valid_t1", p1_key_rsp_valid, 1'b1);
    chk("key_word_t1", 128'(p1_key_rsp_word), 128'h637C777B);
    chk_b("key_no_st_rsp", p1_st_rsp_valid, 1'b0);
    cyc();
    chk_b("key_valid_t2", p1_key_rsp_valid, 1'b0);
    chk("key_word_hold", 128'(p1_key_rsp_word), 128'h637C777B);

    // state alone; input data changes right after accept
    st_req_valid = 1'b1;
    st_req_data = D_A;
    chk_b("st_ready_t0", p1_st_req_ready, 1'b1);
    cyc();
    st_req_valid = 1'b0;
    st_req_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      chk_b($sformatf("st_ready_low_t%0d", k), p1_st_req_ready, 1'b0);
      chk_b($sformatf("st_rsp_idle_t%0d", k), p1_st_rsp_valid, 1'b0);
      cyc();
    end
    chk_b("st_rsp_valid_t5", p1_st_rsp_valid, 1'b1);
    chk("st_rsp_data_t5", p1_st_rsp_data, E_A);
    chk_b("st_ready_t5", p1_st_req_ready, 1'b1);
    cyc();
    chk_b("st_rsp_valid_t6", p1_st_rsp_valid, 1'b0);
    chk("st_rsp_data_hold", p1_st_rsp_data, E_A);

    // contention: state accepted at T, key held from T+1 to T+8
    st_req_valid = 1'b1;
    st_req_data = D_B;
    cyc();
    st_req_valid = 1'b0;
    key_req_word = 32'h53535353;
    for (int k = 1; k <= 9; k++) begin
      key_req_valid = (k <= 8);
      chk_b($sformatf("p1_key_ready_t%0d", k), p1_key_req_ready, (k == 9) || (k % 2 == 1));
      chk_b($sformatf("p1_key_rsp_t%0d", k), p1_key_rsp_valid, (k % 2 == 0) && (k <= 8));
      if (k % 2 == 0 && k <= 8) chk($sformatf("p1_key_word_t%0d", k), 128'(p1_key_rsp_word), 128'hEDEDEDED);
      else chk_b($sformatf("p1_st_ready_t%0d", k), p1_st_req_ready, k == 9);
      chk_b($sformatf("p1_st_rsp_t%0d", k), p1_st_rsp_valid, k == 9);
      chk_b($sformatf("p0_key_ready_t%0d", k), p0_key_req_ready, k >= 5);
      chk_b($sformatf("p0_key_rsp_t%0d", k), p0_key_rsp_valid, k >= 6);
      chk_b($sformatf("p0_st_rsp_t%0d", k), p0_st_rsp_valid, k == 5);
      if (k == 5) chk("p0_st_data", p0_st_rsp_data, E_B);
      else if (k == 9) chk("p1_st_data", p1_st_rsp_data, E_B);
      else if (k >= 6) chk($sformatf("p0_key_word_t%0d", k), 128'(p0_key_rsp_word), 128'hEDEDEDED);
      else chk_b($sformatf("p0_st_ready_t%0d", k), p0_st_req_ready, 1'b0);
      cyc();
    end
    chk_b("p1_key_rsp_t10", p1_key_rsp_valid, 1'b0);
    chk_b("p0_key_rsp_t10", p0_key_rsp_valid, 1'b0);

    // simultaneous state and key accept while idle
    st_req_valid = 1'b1;
    st_req_data = D_C;
    key_req_valid = 1'b1;
    key_req_word = 32'h53000001;
    chk_b("sim_key_ready", p1_key_req_ready, 1'b1);
    cyc();
    st_req_valid = 1'b0;
    key_req_valid = 1'b0;
    chk_b("sim_key_valid", p1_key_rsp_valid, 1'b1);
    chk("sim_key_word", 128'(p1_key_rsp_word), 128'hED63637C);
    chk("sim_p0_key_word", 128'(p0_key_rsp_word), 128'hED63637C);
    for (int k = 2; k <= 4; k++) begin
      cyc();
      chk_b($sformatf("sim_st_idle_t%0d", k), p1_st_rsp_valid, 1'b0);
    end
    cyc();
    chk_b("sim_st_valid_t5", p1_st_rsp_valid, 1'b1);
    chk("sim_st_data", p1_st_rsp_data, E_C);
    chk("sim_p0_st_data", p0_st_rsp_data, E_C);

    // reset during state beat 2
    cyc();
    st_req_valid = 1'b1;
    st_req_data = D_A;
    cyc();
    st_req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk_b("mid_rst_st_ready", p1_st_req_ready, 1'b1);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk_b($sformatf("after_rst_no_rsp_%0d", k), p1_st_rsp_valid, 1'b0);
      chk_b($sformatf("after_rst_ready_%0d", k), p1_st_req_ready, 1'b1);
      cyc();
    end
    chk("after_rst_data", p1_st_rsp_data, 128'd0);
    st_req_valid = 1'b1;
    st_req_data = D_D;
    cyc();
    st_req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_b($sformatf("fresh_idle_t%0d", k), p1_st_rsp_valid, 1'b0);
      cyc();
    end
    chk_b("fresh_valid_t5", p1_st_rsp_valid, 1'b1);
    chk("fresh_data", p1_st_rsp_data, E_D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
